// File: rtl/keypad_lock_pkg.sv
// rtl/keypad_lock_pkg.sv - shared types, RGB codes and digit extraction for the keypad lock
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_ALARM    = 2'd3
  } lock_state_t;

  localparam logic [2:0] RGB_OFF    = 3'b000;
  localparam logic [2:0] RGB_UNLOCK = 3'b010;
  localparam logic [2:0] RGB_ALARM  = 3'b001;

  localparam int VEC_MAX = 256;
  localparam int DIG_MAX = 32;

  // Field i of an n-field, w-bit-per-field vector, field 0 in the most-significant slot.
  function automatic logic [DIG_MAX-1:0] digit(input logic [VEC_MAX-1:0] vec,
                                               input int unsigned n,
                                               input int unsigned w,
                                               input int unsigned i);
    return DIG_MAX'(vec >> ((n - 1 - i) * w)) & ((DIG_MAX'(1) << w) - DIG_MAX'(1));
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_timer.sv
// rtl/keypad_lock_ctrl_timer.sv - loadable down-counter pulsing expired_o on its last counted cycle
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High while one cycle remains, so the owner leaves exactly load_val cycles after loading.
  assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/keypad_lock_ctrl.sv
// rtl/keypad_lock_ctrl.sv - keypad code checker with failure counting, alarm exit and auto-relock
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int CODE_LEN      = 4,
  parameter int EXIT_LEN      = 2,
  parameter int DIGIT_W       = 4,
  parameter int MAX_FAIL      = 3,
  parameter int UNLOCK_CYCLES = 100_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CODE_LEN*DIGIT_W-1:0]    code,
  input  logic [EXIT_LEN*DIGIT_W-1:0]    exit_code,
  input  logic [DIGIT_W-1:0]             cancel_key,
  input  logic                           key_valid,
  input  logic [DIGIT_W-1:0]             key,
  output logic [CODE_LEN-1:0]            progress,
  output logic [2:0]                     rgb,
  output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt,
  output logic                           idle
);

  localparam int IW = $clog2(CODE_LEN);
  localparam int EW = (EXIT_LEN > 1) ? $clog2(EXIT_LEN) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = (UNLOCK_CYCLES > 0) ? $clog2(UNLOCK_CYCLES + 1) : 1;

  lock_state_t   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic [EW-1:0] eidx_q, eidx_d;
  logic [FW-1:0] fail_q, fail_d;
  logic          timer_load, timer_exp;
  logic          code_hit, exit_hit, bad;
  logic [FW-1:0] fail_inc;

  assign code_hit = (DIG_MAX'(key) == digit(VEC_MAX'(code), CODE_LEN, DIGIT_W, int'(idx_q)));
  assign exit_hit = (DIG_MAX'(key) == digit(VEC_MAX'(exit_code), EXIT_LEN, DIGIT_W, int'(eidx_q)));
  assign fail_inc = fail_q + FW'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    eidx_d     = eidx_q;
    fail_d     = fail_q;
    timer_load = 1'b0;
    bad        = err_q | ~code_hit;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_ENTRY;
        idx_d   = '0;
        err_d   = 1'b0;
      end
      ST_ENTRY: begin
        if (key_valid) begin
          // A key equal to the expected digit is a digit even if it is also the cancel key.
          if (!code_hit && key == cancel_key) begin
            idx_d = '0;
            err_d = 1'b0;
          end else if (idx_q == IW'(CODE_LEN - 1)) begin
            idx_d = '0;
            err_d = 1'b0;
            if (!bad) begin
              state_d    = ST_UNLOCKED;
              fail_d     = '0;
              timer_load = 1'b1;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == FW'(MAX_FAIL)) begin
                state_d = ST_ALARM;
                eidx_d  = '0;
              end
            end
          end else begin
            idx_d = idx_q + IW'(1);
            err_d = bad;
          end
        end
      end
      ST_UNLOCKED: begin
        if (key_valid || timer_exp) begin
          state_d = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (key_valid) begin
          if (!exit_hit) begin
            eidx_d = '0;
          end else if (eidx_q == EW'(EXIT_LEN - 1)) begin
            state_d = ST_IDLE;
            eidx_d  = '0;
            fail_d  = '0;
          end else begin
            eidx_d = eidx_q + EW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
      fail_q  <= fail_d;
    end
  end

  if (UNLOCK_CYCLES > 0) begin : g_timer
    lock_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (timer_load),
      .load_val_i (TW'(UNLOCK_CYCLES)),
      .expired_o  (timer_exp)
    );
  end else begin : g_no_timer
    assign timer_exp = 1'b0;
  end

  always_comb begin
    progress = '0;
    rgb      = RGB_OFF;
    case (state_q)
      ST_ENTRY: begin
        for (int i = 0; i < CODE_LEN; i++) begin
          if (i < int'(idx_q)) progress[CODE_LEN-1-i] = 1'b1;
        end
      end
      ST_UNLOCKED: begin
        progress = '1;
        rgb      = RGB_UNLOCK;
      end
      ST_ALARM: rgb = RGB_ALARM;
      default: ;
    endcase
  end

  assign fail_cnt = fail_q;
  assign idle     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb/tb_keypad_lock_ctrl.sv - scoreboard bench for keypad_lock_ctrl against a behavioural lock model
module tb_keypad_lock_ctrl;

  localparam int CODE_LEN = 4;
  localparam int EXIT_LEN = 2;
  localparam int MAX_FAIL = 3;
  localparam int UC       = 20;

  typedef struct packed {
    logic [3:0] progress;
    logic [2:0] rgb;
    logic [1:0] fail;
    logic       idle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] code = 16'h1234;
  logic [7:0]  exit_code = 8'hEF;
  logic [3:0]  cancel_key = 4'hA;
  logic        key_valid = 1'b0;
  logic [3:0]  key = 4'h0;
  logic [3:0]  progress;
  logic [2:0]  rgb;
  logic [1:0]  fail_cnt;
  logic        idle;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  event chk_ev;

  // Model: mode 0 idle, 1 entering, 2 open, 3 alarm; ent holds match flags of digits typed so far.
  int m_mode, m_fail, m_epos, m_held;
  bit ent[$];

  keypad_lock_ctrl #(
    .CODE_LEN(CODE_LEN), .EXIT_LEN(EXIT_LEN), .DIGIT_W(4),
    .MAX_FAIL(MAX_FAIL), .UNLOCK_CYCLES(UC)
  ) dut (
    .clk(clk), .rst(rst), .code(code), .exit_code(exit_code), .cancel_key(cancel_key),
    .key_valid(key_valid), .key(key), .progress(progress), .rgb(rgb),
    .fail_cnt(fail_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic int cdig(int p);
    return int'((code >> ((CODE_LEN - 1 - p) * 4)) & 16'hF);
  endfunction

  function automatic int edig(int p);
    return int'((exit_code >> ((EXIT_LEN - 1 - p) * 4)) & 8'hF);
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_fail = 0; m_epos = 0; m_held = 0;
    ent.delete();
  endfunction

  function automatic void model_step(bit kv, int k);
    bit ok;
    case (m_mode)
      0: begin m_mode = 1; ent.delete(); end
      1: if (kv) begin
        if (k == cdig(ent.size())) ent.push_back(1'b1);
        else if (k == int'(cancel_key)) ent.delete();
        else ent.push_back(1'b0);
        if (ent.size() == CODE_LEN) begin
          ok = 1'b1;
          foreach (ent[i]) ok &= ent[i];
          if (ok) begin m_mode = 2; m_fail = 0; m_held = 0; end
          else begin
            m_fail++;
            if (m_fail == MAX_FAIL) begin m_mode = 3; m_epos = 0; end
          end
          ent.delete();
        end
      end
      2: if (kv) m_mode = 0;
         else begin m_held++; if (m_held == UC) m_mode = 0; end
      default: if (kv) begin
        if (k == edig(m_epos)) begin
          m_epos++;
          if (m_epos == EXIT_LEN) begin m_mode = 0; m_fail = 0; m_epos = 0; end
        end else m_epos = 0;
      end
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int n;
    n = ent.size();
    e.progress = (m_mode == 1) ? 4'(((1 << n) - 1) << (CODE_LEN - n)) : (m_mode == 2) ? 4'hF : 4'h0;
    e.rgb      = (m_mode == 2) ? 3'b010 : (m_mode == 3) ? 3'b001 : 3'b000;
    e.fail     = 2'(m_fail);
    e.idle     = (m_mode == 0);
    return e;
  endfunction

  task automatic step(bit kv, int k);
    @(negedge clk);
    #1;
    key_valid = kv;
    key = 4'(k);
    model_step(kv, k);
    sb.push_back(model_out());
  endtask

  task automatic press(int k);
    step(1'b1, k);
  endtask

  task automatic wait_n(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic press_seq(input logic [31:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) press(int'((s >> (i * 4)) & 32'hF));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    key_valid = 1'b0;
    #1;
    model_reset();
    sb.push_back(model_out());
    ->chk_ev;
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_step(1'b0, 0);
    sb.push_back(model_out());
  endtask

  initial begin : monitor
    exp_t e, g;
    forever begin
      @(negedge clk or chk_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = {progress, rgb, fail_cnt, idle};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got progress=%b rgb=%b fail=%0d idle=%b, want progress=%b rgb=%b fail=%0d idle=%b",
                   $time, g.progress, g.rgb, g.fail, g.idle, e.progress, e.rgb, e.fail, e.idle);
        end
      end
    end
  end

  initial begin : driver
    int r, k;
    model_reset();
    do_reset();
    press_seq(32'h1234, 4);
    press(5);
    wait_n(2);
    press_seq(32'h12A1234, 7);
    press(0);
    wait_n(2);
    repeat (3) press_seq(32'h5555, 4);
    press_seq(32'hE5EF, 4);
    wait_n(3);
    press_seq(32'h1234, 4);
    wait_n(UC + 4);
    press_seq(32'h1234, 4);
    wait_n(4);
    press(7);
    wait_n(2);
    press_seq(32'h12, 2);
    do_reset();
    press_seq(32'h34, 2);
    wait_n(2);
    @(negedge clk);
    cancel_key = 4'h2;
    press_seq(32'h1234, 4);
    press(9);
    wait_n(1);
    @(negedge clk);
    cancel_key = 4'hA;
    wait_n(1);
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
        wait_n(UC + 2);
      end else if ($urandom_range(0, 2) == 0) begin
        step(1'b0, 0);
      end else begin
        r = $urandom_range(0, 9);
        if (r < 5) k = (m_mode == 3) ? edig(m_epos) : cdig((m_mode == 1) ? ent.size() : 0);
        else if (r == 5) k = 4'hA;
        else if (r < 8) k = $urandom_range(0, 15);
        else k = (r == 8) ? 4'hE : 4'hF;
        press(k);
      end
    end
    wait_n(2);
    @(negedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_lock_ctrl.md
# keypad_lock_ctrl

Parametrised keypad lock controller for the 7-segment keypad lock design, sitting between the keypad scanner (debounced `key_valid`/`key`) and the LED/RGB drivers. It checks a CODE_LEN-digit code and counts consecutive failed attempts, raising an alarm after MAX_FAIL failures; an EXIT_LEN-digit exit sequence clears the alarm. A cancel key restarts entry without counting a failure, and an optional timer relocks the door automatically.

## Interface
- CODE_LEN, 4: digits in the unlock code (≥2)
- EXIT_LEN, 2: digits in the alarm exit sequence (≥1)
- DIGIT_W, 4: bits per key code
- MAX_FAIL, 3: failed attempts before alarm (≥1)
- UNLOCK_CYCLES, 100_000_000: auto-relock timeout in clk cycles; 0 disables it
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- code  in  CODE_LEN*DIGIT_W  unlock code; digit 0 is the most-significant field
- exit_code  in  EXIT_LEN*DIGIT_W  alarm exit sequence; digit 0 is the MS field
- cancel_key  in  DIGIT_W  key value that restarts entry
- key_valid  in  1  single-cycle strobe, one per key press
- key  in  DIGIT_W  key value, qualified by key_valid
- progress  out  CODE_LEN  thermometer of digits entered, filled from the MSB
- rgb  out  3  010 = unlocked, 001 = alarm, 000 otherwise
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed attempts
- idle  out  1  high while in IDLE

## Operation
- States: IDLE, ENTRY, UNLOCKED, ALARM. Internal registers: entry index `idx`, error flag `err`, exit index `eidx`, relock timer.
- **IDLE:** lasts exactly one cycle, then moves to ENTRY with idx=0 and err=0. Keys in IDLE are ignored. IDLE is entered from reset, after a relock and after an alarm exit.
- **ENTRY, key accepted:**
  - Code match has priority: if key == code digit idx, accept it as a digit.
  - Otherwise, if key == cancel_key, set idx=0, clear err, leave fail_cnt unchanged.
  - Otherwise accept the key as a digit with err set.
  - Every digit increments idx.
- **ENTRY, last digit (idx = CODE_LEN-1):**
  - No error: go to UNLOCKED and clear fail_cnt.
  - Error: increment fail_cnt. If the new value equals MAX_FAIL, go to ALARM. Otherwise stay in ENTRY with idx=0 and err=0.
- **UNLOCKED:** the timer loads UNLOCK_CYCLES on entry. Any key_valid, or timer expiry when UNLOCK_CYCLES≠0, goes to IDLE.
- **ALARM:**
  - eidx=0 on entry.
  - key == exit_code digit eidx increments eidx. The final exit digit goes to IDLE and clears fail_cnt.
  - A mismatching key sets eidx=0 and does not re-test itself as digit 0.
  - fail_cnt holds MAX_FAIL for the whole alarm.
- **Outputs** are decoded from state and idx:
  - ENTRY: progress MSBs set = idx (e.g. idx=2, CODE_LEN=4 → 1100).
  - UNLOCKED: progress all ones.
  - IDLE and ALARM: progress all zeros.
- **Reset values:** state IDLE, progress 0, rgb 000, fail_cnt 0, idle 1. Reset asserted mid-sequence discards idx, err, eidx, fail_cnt and the timer.
- code, exit_code and cancel_key are sampled only on key_valid cycles; changing them between keys is legal.

## Timing
- key_valid is sampled at the rising clk edge. The state and all outputs reflect that key after the same edge (1-cycle latency).
- Keys on back-to-back cycles are each processed.
- Timeout: UNLOCKED is held for exactly UNLOCK_CYCLES cycles with no key, then IDLE on the next edge.
- A key in the same cycle as timer expiry goes to IDLE once; the key is not re-used.
- At most one transition per cycle.

## Structure
- Package `keypad_lock_pkg`: state enum `lock_state_t`, RGB constants `RGB_OFF/RGB_UNLOCK/RGB_ALARM`, and helper function `digit(vec, i)` for MS-first field extraction.
- One sub-module, `lock_timer`: a loadable down-counter with an `expired` pulse and width $clog2(UNLOCK_CYCLES+1). It is tied off when UNLOCK_CYCLES=0.

## Test plan
Bench settings: code=16'h1234, exit_code=8'hEF, cancel_key=4'hA, MAX_FAIL=3, UNLOCK_CYCLES=20.
- Reset release, then keys 1,2,3,4 → idle for 1 cycle; progress 1000, 1100, 1110; after key 4, rgb=010, progress=1111, fail_cnt=0.
- Keys 1,2,A,1,2,3,4 → the A key sets progress 0000 without changing fail_cnt; the following 1,2,3,4 unlocks.
- Three wrong codes 5,5,5,5 → fail_cnt 1, 2, then ALARM (rgb=001, fail_cnt=3). Keys E,5,E,F → the 5 sets eidx=0; F then idles for 1 cycle; fail_cnt=0; progress=0000.
- Unlock, then no keys → rgb=010 for 20 cycles, idle pulse, back to ENTRY. Repeat with one key at cycle 5 → immediate relock.
- rst asserted after keys 1,2 → outputs reset asynchronously; keys 3,4 alone do not unlock.
- cancel_key=4'h2 with code 16'h1234, keys 1,2,3,4 → unlocks (code match beats cancel).
